// File: rtl/traffic_phase_scheduler.sv
// Timed NS/EW intersection sequencer with a pedestrian walk phase.
// Moore outputs; green timing adapts to demand between min and max green.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN    = 8,
  parameter int MAX_GREEN    = 32,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 10,
  parameter int CNT_W        = 6
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       NSCar,
  input  logic       EWCar,
  input  logic       PedReq,
  output logic [1:0] NSLite,
  output logic [1:0] EWLite,
  output logic       Walk,
  output logic       PedAck,
  output logic [2:0] Phase
);

  typedef enum logic [2:0] {
    NS_G    = 3'd0,
    NS_Y    = 3'd1,
    ALL_RED = 3'd2,
    EW_G    = 3'd3,
    EW_Y    = 3'd4,
    WALK    = 3'd5
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;

  localparam logic [CNT_W-1:0] T_MIN = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] T_AR  = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] T_WK  = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] T_SAT = {CNT_W{1'b1}};

  state_t           state, state_n;
  dir_t             next_dir, dir_n;
  logic [CNT_W-1:0] timer;
  logic             ped_pending, ped_n;
  logic             ns_go, ew_go;

  // Leave green only once min green has elapsed and someone else is waiting.
  assign ns_go = (timer >= T_MIN) && (EWCar || ped_pending)
               && (!NSCar || timer >= T_MAX);
  assign ew_go = (timer >= T_MIN) && (NSCar || ped_pending)
               && (!EWCar || timer >= T_MAX);

  always_comb begin
    state_n = state;
    dir_n   = next_dir;
    case (state)
      NS_G: if (ns_go) state_n = NS_Y;
      NS_Y: begin
        if (timer == T_YEL) begin
          state_n = ALL_RED;
          dir_n   = DIR_EW;
        end
      end
      EW_G: if (ew_go) state_n = EW_Y;
      EW_Y: begin
        if (timer == T_YEL) begin
          state_n = ALL_RED;
          dir_n   = DIR_NS;
        end
      end
      ALL_RED: begin
        if (timer == T_AR) begin
          if (ped_pending)
            state_n = WALK;
          else
            state_n = (next_dir == DIR_EW) ? EW_G : NS_G;
        end
      end
      WALK: begin
        if (timer == T_WK)
          state_n = (next_dir == DIR_EW) ? EW_G : NS_G;
      end
      default: state_n = ALL_RED;
    endcase
  end

  // Entering WALK clears the request even if the button is held that cycle.
  always_comb begin
    ped_n = ped_pending;
    if (state_n == WALK && state != WALK)
      ped_n = 1'b0;
    else if (PedReq && state != WALK)
      ped_n = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= NS_G;
      next_dir    <= DIR_EW;
      timer       <= '0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_n;
      next_dir    <= dir_n;
      ped_pending <= ped_n;
      if (state_n != state)
        timer <= '0;
      else if (timer != T_SAT)
        timer <= timer + 1'b1;
    end
  end

  always_comb begin
    NSLite = RED;
    EWLite = RED;
    Walk   = 1'b0;
    case (state)
      NS_G:    NSLite = GRN;
      NS_Y:    NSLite = YEL;
      EW_G:    EWLite = GRN;
      EW_Y:    EWLite = YEL;
      WALK:    Walk   = 1'b1;
      default: ;
    endcase
  end

  assign PedAck = ped_pending;
  assign Phase  = state;

endmodule
